// File: rtl/online_digit_sequencer.sv
// rtl/online_digit_sequencer.sv - sequences operand digit pairs into an online divider and collects its quotient digits
module online_digit_sequencer #(
    parameter int PREC  = 8,
    parameter int DELTA = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_digit,
    input  logic [1:0] d_digit,
    output logic       div_en,
    output logic [1:0] div_x,
    output logic [1:0] div_d,
    input  logic [1:0] div_q,
    output logic       out_valid,
    output logic [1:0] out_q,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       err_digit
);

    localparam int AW = $clog2(PREC + 1);
    localparam int SW = $clog2(PREC + DELTA + 1);
    localparam int DW = $clog2(DELTA + 1);

    localparam logic [AW-1:0] PAIRS       = AW'(PREC);
    localparam logic [AW-1:0] LAST_PAIR   = AW'(PREC - 1);
    localparam logic [SW-1:0] FIRST_KEPT  = SW'(DELTA);
    localparam logic [SW-1:0] LAST_STEP   = SW'(PREC + DELTA - 1);
    localparam logic [DW-1:0] DRAIN_STEPS = DW'(DELTA);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [SW-1:0] step_q, step_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          div_en_q, div_en_d;
    logic [1:0]    div_x_q, div_x_d;
    logic [1:0]    div_d_q, div_d_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_q_q, out_q_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept;

    // The illegal code 11 is forwarded as a zero digit.
    function automatic logic [1:0] legalize(input logic [1:0] dig);
        return (dig == 2'b11) ? 2'b00 : dig;
    endfunction

    assign in_ready  = (state_q == ST_FEED) && (acc_q < PAIRS);
    assign accept    = in_valid && in_ready;
    assign div_en    = div_en_q;
    assign div_x     = div_x_q;
    assign div_d     = div_d_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_last  = done_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_digit = err_q;

    // Next-state: feed pairs, drain the divider's online delay, keep quotient digits past the delay.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        drain_d     = drain_q;
        err_d       = err_q;
        div_en_d    = 1'b0;
        div_x_d     = 2'b00;
        div_d_d     = 2'b00;
        out_valid_d = 1'b0;
        out_q_d     = 2'b00;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_FEED;
                    acc_d   = '0;
                    step_d  = '0;
                    drain_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_FEED: begin
                if (accept) begin
                    div_en_d = 1'b1;
                    div_x_d  = legalize(x_digit);
                    div_d_d  = legalize(d_digit);
                    acc_d    = acc_q + AW'(1);
                    if (x_digit == 2'b11 || d_digit == 2'b11) begin
                        err_d = 1'b1;
                    end
                    if (acc_q == LAST_PAIR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q < DRAIN_STEPS) begin
                    div_en_d = 1'b1;
                    drain_d  = drain_q + DW'(1);
                end
                // Stay through the done cycle so busy covers it.
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The divider's digit for the step that is ending right now.
        if (div_en_q) begin
            step_d = step_q + SW'(1);
            if (div_q == 2'b11) begin
                err_d = 1'b1;
            end
            if (step_q >= FIRST_KEPT) begin
                out_valid_d = 1'b1;
                out_q_d     = legalize(div_q);
                done_d      = (step_q == LAST_STEP);
            end
        end

        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            div_en_d    = 1'b0;
            div_x_d     = 2'b00;
            div_d_d     = 2'b00;
            out_valid_d = 1'b0;
            out_q_d     = 2'b00;
            done_d      = 1'b0;
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            drain_q     <= '0;
            div_en_q    <= 1'b0;
            div_x_q     <= 2'b00;
            div_d_q     <= 2'b00;
            out_valid_q <= 1'b0;
            out_q_q     <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            drain_q     <= drain_d;
            div_en_q    <= div_en_d;
            div_x_q     <= div_x_d;
            div_d_q     <= div_d_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_online_digit_sequencer.sv
// tb/tb_online_digit_sequencer.sv - scoreboard bench for online_digit_sequencer
module tb_online_digit_sequencer;

    localparam int PREC  = 8;
    localparam int DELTA = 3;
    localparam int NSTEP = PREC + DELTA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] x_digit = 2'b00;
    logic [1:0] d_digit = 2'b00;
    logic [1:0] div_q = 2'b00;
    logic       in_ready, div_en, out_valid, out_last, busy, done, err_digit;
    logic [1:0] div_x, div_d, out_q;

    online_digit_sequencer #(.PREC(PREC), .DELTA(DELTA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .x_digit(x_digit), .d_digit(d_digit),
        .div_en(div_en), .div_x(div_x), .div_d(div_d), .div_q(div_q),
        .out_valid(out_valid), .out_q(out_q), .out_last(out_last),
        .busy(busy), .done(done), .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] q;
        logic       last;
    } exp_t;

    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       exp_q[$];
    logic [3:0] pair_q[$];
    logic [1:0] qlist[NSTEP];
    int         en_seen = 0;
    int         run_len = 0;
    int         max_run = 0;
    int         out_cnt = 0;
    logic       exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [1:0] legal(input logic [1:0] dig);
        return (dig == 2'b11) ? 2'b00 : dig;
    endfunction

    function automatic logic [15:0] all_outs();
        return {4'b0, in_ready, div_en, div_x, div_d, out_valid, out_q, out_last, busy, done, err_digit};
    endfunction

    // Divider model: checks forwarded digits and presents its scripted quotient digit per step.
    always @(negedge clk) begin
        if (rst_n && div_en) begin
            if (pair_q.size() == 0) begin
                chk("unexpected_div_step", 32'(div_en), 32'd0);
            end else begin
                chk("div_pair", 32'({div_x, div_d}), 32'(pair_q.pop_front()));
            end
            if (en_seen < NSTEP) div_q = qlist[en_seen];
            else div_q = 2'b00;
            en_seen++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
            div_q   = 2'($urandom_range(0, 3));
        end
    end

    // Output monitor: every out_valid pops one expected quotient digit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_q", 32'(out_q), 32'(e.q));
                    chk("out_last_done", 32'({out_last, done}), 32'({e.last, e.last}));
                end
            end else if (out_q != 2'b00 || out_last || done) begin
                chk("idle_out_quiet", 32'({out_q, out_last, done}), 32'd0);
            end
        end
    end

    task automatic begin_div(input int bad_q_step);
        exp_q.delete();
        pair_q.delete();
        en_seen = 0;
        max_run = 0;
        out_cnt = 0;
        exp_err = 1'b0;
        for (int k = 0; k < NSTEP; k++) begin
            qlist[k] = 2'($urandom_range(0, 2));
            if (k == bad_q_step) qlist[k] = 2'b11;
            if (qlist[k] == 2'b11) exp_err = 1'b1;
        end
        for (int k = DELTA; k < NSTEP; k++) begin
            exp_q.push_back({legal(qlist[k]), (k == NSTEP - 1)});
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clear", 32'(err_digit), 32'd0);
    endtask

    task automatic feed(input int n, input int gap_after, input int gap_len,
                        input int bad_pos, input int busy_start_at);
        logic [1:0] x, d;
        logic rdy, acc;
        for (int i = 0; i < n; i++) begin
            if (i == gap_after) begin
                repeat (gap_len) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            x = 2'($urandom_range(0, 2));
            d = 2'($urandom_range(0, 2));
            if (i == bad_pos) x = 2'b11;
            in_valid = 1'b1;
            x_digit  = x;
            d_digit  = d;
            start    = (i == busy_start_at);
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk); rdy = in_ready;
                @(posedge clk); #1;
                acc = rdy;
            end
            start = 1'b0;
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
            end else begin
                pair_q.push_back({legal(x), legal(d)});
                if (x == 2'b11 || d == 2'b11) exp_err = 1'b1;
            end
        end
        in_valid = 1'b0;
        x_digit  = 2'b00;
        d_digit  = 2'b00;
        if (n == PREC) repeat (DELTA) pair_q.push_back(4'b0);
    endtask

    task automatic wait_done(input int exp_run);
        logic got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk); got = done;
        end
        chk("done_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("step_count", 32'(en_seen), 32'(NSTEP));
        chk("out_count", 32'(out_cnt), 32'(PREC));
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("err_digit", 32'(err_digit), 32'(exp_err));
        if (exp_run > 0) chk("div_en_run", 32'(max_run), 32'(exp_run));
    endtask

    initial begin
        logic hit;
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // back-to-back pairs
        begin_div(-1);
        feed(PREC, -1, 0, -1, -1);
        wait_done(NSTEP);

        // two-cycle gap after the fourth pair
        begin_div(-1);
        feed(PREC, 4, 2, -1, -1);
        wait_done(7);

        // illegal x digit on the fifth pair, flag is sticky
        begin_div(-1);
        feed(PREC, -1, 0, 4, -1);
        wait_done(NSTEP);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", 32'(err_digit), 32'd1);

        // illegal divider digit on a kept step
        begin_div(5);
        feed(PREC, -1, 0, -1, -1);
        wait_done(NSTEP);

        // start pulsed while busy is ignored
        begin_div(-1);
        feed(PREC, -1, 0, -1, 3);
        wait_done(NSTEP);

        // abort during drain step 1
        begin_div(-1);
        feed(PREC, -1, 0, -1, -1);
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            if (div_en && en_seen == PREC + 1) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_point_reached", 32'(hit), 32'd1);
        abort = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_idle", 32'({busy, div_en, out_valid, done}), 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("abort_no_more_out", 32'(exp_q.size()), 32'd0);
        chk("abort_out_count", 32'(out_cnt), 32'(PREC - 2));

        begin_div(-1);
        feed(PREC, -1, 0, -1, -1);
        wait_done(NSTEP);

        // start and abort together in idle
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        chk("start_abort_idle", 32'({busy, in_ready}), 32'd0);

        // asynchronous reset mid-division
        begin_div(-1);
        feed(3, -1, 0, 0, -1);
        chk("err_before_reset", 32'(err_digit), 32'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("midcycle_reset_outputs", 32'(all_outs()), 32'd0);
        exp_q.delete();
        pair_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 chk("stay_idle_after_reset", 32'({busy, in_ready, div_en}), 32'd0);

        // randomized divisions
        repeat (4) begin
            begin_div(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NSTEP - 1)) : -1);
            feed(PREC, int'($urandom_range(0, PREC - 1)), int'($urandom_range(0, 3)), -1, -1);
            wait_done(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/online_digit_sequencer.md
ONLINE_DIGIT_SEQUENCER -- requirements
Module: online_digit_sequencer

Interface
REQ-001 SHALL have parameter PREC, default 8: operand/quotient precision in radix-2 signed digits, legal range 2..128.
REQ-002 SHALL have parameter DELTA, default 3: online delay of the attached divider in steps, legal range 1..8.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, width 1: begin one division; honoured only in IDLE.
REQ-006 SHALL have port abort, input, width 1: synchronous cancel of the current division.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), x_digit (input, 2), d_digit (input, 2): operand digit pair stream, MSB first, valid/ready handshake.
REQ-008 SHALL have ports div_en (output, 1), div_x (output, 2), div_d (output, 2), div_q (input, 2): digit-serial link to the divider; div_q is the divider's digit for the current div_en step.
REQ-009 SHALL have ports out_valid (output, 1), out_q (output, 2), out_last (output, 1): quotient digit stream, no backpressure.
REQ-010 SHALL have ports busy (output, 1), done (output, 1), err_digit (output, 1).

Function
REQ-011 SHALL use the digit encoding 00 = 0, 01 = +1, 10 = -1, 11 = illegal on every 2-bit digit port.
REQ-012 SHALL implement states IDLE, FEED, DRAIN; IDLE -> FEED on start; FEED -> DRAIN after PREC accepted pairs; DRAIN -> IDLE after DELTA drain steps and the final quotient digit is emitted.
REQ-013 SHALL drive in_ready = 1 only in FEED while fewer than PREC pairs have been accepted; in IDLE/DRAIN in_ready = 0.
REQ-014 SHALL, on each accepted pair (in_valid & in_ready at the edge), register div_en = 1 and div_x/div_d = the pair for exactly the next cycle.
REQ-015 SHALL hold div_en = 0 and div_x = div_d = 00 on any cycle with no step, so an in_valid gap stalls the divider cycle-for-cycle.
REQ-016 SHALL, in DRAIN, assert div_en = 1 with div_x = div_d = 00 on DELTA consecutive cycles.
REQ-017 SHALL keep a step counter (width clog2(PREC+DELTA+1)), cleared on start, incremented on each div_en cycle; total steps per division = PREC + DELTA.
REQ-018 SHALL sample div_q at the edge ending each div_en cycle; steps 0..DELTA-1 are discarded; step k >= DELTA yields quotient digit k-DELTA.
REQ-019 SHALL present each kept digit on out_q with out_valid = 1 for one cycle, the cycle after sampling; out_q = 00 when out_valid = 0.
REQ-020 SHALL assert out_last and done together, for one cycle, with the PREC-th out_valid; the state is IDLE on the following cycle.
REQ-021 SHALL emit exactly PREC out_valid pulses per completed division, independent of input stalls.
REQ-022 SHALL replace an illegal input digit (11) by 00 before forwarding and set err_digit, sticky until the next honoured start or reset.
REQ-023 SHALL treat an illegal div_q (11) as 00 and set err_digit.
REQ-024 SHALL ignore start while busy; start and abort asserted together in IDLE: abort wins, state stays IDLE.
REQ-025 SHALL, on abort in FEED/DRAIN, return to IDLE next cycle, drive div_en/out_valid/done low, and emit no further digits.
REQ-026 SHALL drive busy = 1 in FEED and DRAIN and on the done cycle, 0 otherwise.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state IDLE, counters 0, and all outputs 0 (in_ready, div_en, div_x, div_d, out_valid, out_q, out_last, busy, done, err_digit).
REQ-028 SHALL discard any in-flight division on reset; operation resumes only on a new start after rst_n rises.

Verification (PREC=8, DELTA=3)
REQ-029 SHALL pass: rst_n pulsed low mid-cycle -> all outputs 0 without waiting for a clk edge.
REQ-030 SHALL pass: start, 8 back-to-back pairs -> div_en high 11 consecutive cycles, last 3 with 00 digits; 8 out_valid pulses equal to div_q of steps 3..10; out_last = done = 1 on the 8th.
REQ-031 SHALL pass: in_valid low 2 cycles after the 4th pair -> 2-cycle div_en gap, still exactly 8 quotient digits, done once.
REQ-032 SHALL pass: x_digit = 11 on the 5th pair -> div_x = 00 on that step, err_digit = 1 until the next start.
REQ-033 SHALL pass: abort during DRAIN step 1 -> busy = 0 and no out_valid after the next cycle; a subsequent start runs a full 8-digit division.
REQ-034 SHALL pass: start pulsed while busy -> ignored, step count and output count unchanged.
